// File: rtl/dmem_ctrl.sv
// Data-memory controller for the MEM stage: RV32I load/store widths on a
// word-organised single-port RAM, with sub-word stores done as read-modify-write.

module dmem_lane #(
    parameter int LANE = 0
) (
    input  logic [1:0]  i_lane,
    input  logic        i_half,
    input  logic [7:0]  i_old,
    input  logic [15:0] i_new,
    output logic [7:0]  o_byte
);
    localparam logic [1:0] LID = 2'(LANE);

    logic       w_hit;
    logic [7:0] w_src;

    // A half store covers the lane pair selected by lane[1]; its upper byte lands in the odd lane.
    assign w_hit  = i_half ? (i_lane[1] == LID[1]) : (i_lane == LID);
    assign w_src  = (i_half && LID[0]) ? i_new[15:8] : i_new[7:0];
    assign o_byte = w_hit ? w_src : i_old;
endmodule

module dmem_ctrl #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [DM_ADDRESS-1:0] addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [2:0]            func3,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_valid,
    output logic                  busy,
    output logic                  err
);
    localparam int WORDS     = 1 << (DM_ADDRESS - 2);
    localparam int NUM_LANES = DATA_W / 8;

    typedef enum logic {
        S_IDLE,
        S_RMW
    } state_t;

    state_t r_state;

    logic [DATA_W-1:0]     r_mem [WORDS];
    logic [DM_ADDRESS-3:0] r_idx;
    logic [1:0]            r_lane;
    logic                  r_half;
    logic [15:0]           r_wdata;
    logic [DATA_W-1:0]     r_word;

    logic [DM_ADDRESS-3:0]       w_idx;
    logic [1:0]                  w_lane;
    logic                        w_req;
    logic                        w_fault;
    logic                        w_sw;
    logic                        w_we;
    logic [DM_ADDRESS-3:0]       w_waddr;
    logic [DATA_W-1:0]           w_wdata;
    logic [DATA_W-1:0]           w_rword;
    logic [NUM_LANES-1:0][7:0]   w_rbytes;
    logic [7:0]                  w_byte;
    logic [15:0]                 w_half;
    logic [DATA_W-1:0]           w_ld_ext;
    logic [NUM_LANES-1:0][7:0]   w_old;
    logic [NUM_LANES-1:0][7:0]   w_mrg;

    assign w_idx  = addr[DM_ADDRESS-1:2];
    assign w_lane = addr[1:0];
    assign w_req  = MemRead | MemWrite;
    assign busy   = (r_state == S_RMW);

    always_comb begin
        w_fault = 1'b0;
        case (func3)
            3'b000:         w_fault = 1'b0;
            3'b001:         w_fault = addr[0];
            3'b010:         w_fault = |addr[1:0];
            3'b100, 3'b101: w_fault = MemWrite | (func3[0] & addr[0]);
            default:        w_fault = 1'b1;
        endcase
    end

    // Read side: word and lane extraction feeding the registered load result.
    assign w_rword  = r_mem[w_idx];
    assign w_rbytes = w_rword;
    assign w_byte   = w_rbytes[w_lane];
    assign w_half   = w_lane[1] ? w_rword[31:16] : w_rword[15:0];

    always_comb begin
        w_ld_ext = '0;
        case (func3)
            3'b000:  w_ld_ext = {{(DATA_W-8){w_byte[7]}}, w_byte};
            3'b001:  w_ld_ext = {{(DATA_W-16){w_half[15]}}, w_half};
            3'b010:  w_ld_ext = w_rword;
            3'b100:  w_ld_ext = {{(DATA_W-8){1'b0}}, w_byte};
            3'b101:  w_ld_ext = {{(DATA_W-16){1'b0}}, w_half};
            default: w_ld_ext = '0;
        endcase
    end

    assign w_old = r_word;

    genvar g;
    generate
        for (g = 0; g < NUM_LANES; g++) begin : g_lane
            dmem_lane #(.LANE(g)) u_lane (
                .i_lane (r_lane),
                .i_half (r_half),
                .i_old  (w_old[g]),
                .i_new  (r_wdata),
                .o_byte (w_mrg[g])
            );
        end
    endgenerate

    // Write side: SW in its accept cycle, merged word in the RMW cycle; reset cancels either.
    assign w_sw    = (r_state == S_IDLE) && MemWrite && !w_fault && (func3 == 3'b010);
    assign w_we    = !reset && (w_sw || (r_state == S_RMW));
    assign w_waddr = (r_state == S_RMW) ? r_idx : w_idx;
    assign w_wdata = (r_state == S_RMW) ? w_mrg : wr_data;

    always_ff @(posedge clk) begin
        if (w_we)
            r_mem[w_waddr] <= w_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            err      <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            err      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        err <= w_fault;
                        if (!MemWrite) begin
                            rd_valid <= 1'b1;
                            rd_data  <= w_fault ? '0 : w_ld_ext;
                        end else if (!w_fault && !func3[1]) begin
                            r_state <= S_RMW;
                            r_idx   <= w_idx;
                            r_lane  <= w_lane;
                            r_half  <= func3[0];
                            r_wdata <= wr_data[15:0];
                            r_word  <= w_rword;
                        end
                    end
                end
                S_RMW:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_ctrl.sv
// Randomized check of dmem_ctrl against a byte-array memory model.

module tb_dmem_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead;
    logic        MemWrite;
    logic [8:0]  addr;
    logic [31:0] wr_data;
    logic [2:0]  func3;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        busy;
    logic        err;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0]  mb [512];
    logic        m_rmw;
    logic [8:0]  p_a;
    int          p_n;
    logic [31:0] p_d;
    logic [31:0] e_rd;
    logic        e_vld;
    logic        e_err;

    dmem_ctrl #(.DM_ADDRESS(9), .DATA_W(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .addr     (addr),
        .wr_data  (wr_data),
        .func3    (func3),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic is_fault(input logic st, input logic [8:0] a, input logic [2:0] f3);
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) return 1'b1;
        if (st && f3[2]) return 1'b1;
        return (int'(a) % size_of(f3)) != 0;
    endfunction

    function automatic logic [31:0] load_val(input logic [8:0] a, input logic [2:0] f3);
        int          n;
        logic [31:0] v;
        logic [8:0]  ba;
        n = size_of(f3);
        v = '0;
        for (int k = 0; k < n; k++) begin
            ba = a + 9'(k);
            v  = v | (32'(mb[ba]) << (8 * k));
        end
        if (!f3[2] && n < 4 && v[8*n-1])
            v = v | ~((32'd1 << (8 * n)) - 32'd1);
        return v;
    endfunction

    task automatic step(input logic rd, input logic wr, input logic [8:0] a,
                        input logic [31:0] d, input logic [2:0] f3, input logic rst);
        logic       flt;
        logic [8:0] ba;
        MemRead  = rd;
        MemWrite = wr;
        addr     = a;
        wr_data  = d;
        func3    = f3;
        reset    = rst;
        chk("busy", 32'(busy), 32'(m_rmw));
        e_vld = 1'b0;
        e_err = 1'b0;
        if (rst) begin
            m_rmw = 1'b0;
            e_rd  = '0;
        end else if (m_rmw) begin
            for (int k = 0; k < p_n; k++) begin
                ba     = p_a + 9'(k);
                mb[ba] = p_d[8*k +: 8];
            end
            m_rmw = 1'b0;
        end else if (rd || wr) begin
            flt   = is_fault(wr, a, f3);
            e_err = flt;
            if (wr) begin
                if (!flt && f3 == 3'b010) begin
                    for (int k = 0; k < 4; k++) begin
                        ba     = a + 9'(k);
                        mb[ba] = d[8*k +: 8];
                    end
                end else if (!flt) begin
                    m_rmw = 1'b1;
                    p_a   = a;
                    p_n   = size_of(f3);
                    p_d   = d;
                end
            end else begin
                e_vld = 1'b1;
                e_rd  = flt ? 32'd0 : load_val(a, f3);
            end
        end
        @(posedge clk);
        #1;
        chk("rd_valid", 32'(rd_valid), 32'(e_vld));
        chk("err", 32'(err), 32'(e_err));
        chk("rd_data", rd_data, e_rd);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 9'h000, 32'h0, 3'b000, 1'b0);
    endtask

    initial begin
        logic       rd, wr, rst;
        logic [2:0] f3;
        for (int i = 0; i < 512; i++) mb[i] = 8'h00;
        m_rmw = 1'b0;
        e_rd  = '0;
        reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0;
        addr = '0; wr_data = '0; func3 = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_rd_data", rd_data, 32'h0);
        chk("rst_rd_valid", 32'(rd_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        reset = 1'b0;

        for (int w = 0; w < 128; w++)
            step(1'b0, 1'b1, 9'(w * 4), $urandom, 3'b010, 1'b0);

        step(1'b0, 1'b1, 9'h010, 32'hDEADBEEF, 3'b010, 1'b0);
        step(1'b1, 1'b0, 9'h010, 32'h0, 3'b010, 1'b0);
        chk("sw_lw_010", rd_data, 32'hDEADBEEF);

        step(1'b0, 1'b1, 9'h020, 32'h0, 3'b010, 1'b0);
        step(1'b0, 1'b1, 9'h021, 32'h000000AA, 3'b000, 1'b0);
        chk("sb_busy", 32'(busy), 32'h1);
        idle();
        step(1'b0, 1'b1, 9'h023, 32'h00000055, 3'b000, 1'b0);
        idle();
        step(1'b1, 1'b0, 9'h020, 32'h0, 3'b010, 1'b0);
        chk("sb_lanes", rd_data, 32'h5500AA00);

        step(1'b0, 1'b1, 9'h030, 32'h80FF7F01, 3'b010, 1'b0);
        step(1'b1, 1'b0, 9'h033, 32'h0, 3'b000, 1'b0);
        chk("lb_033", rd_data, 32'hFFFFFF80);
        step(1'b1, 1'b0, 9'h033, 32'h0, 3'b100, 1'b0);
        chk("lbu_033", rd_data, 32'h00000080);
        step(1'b1, 1'b0, 9'h032, 32'h0, 3'b001, 1'b0);
        chk("lh_032", rd_data, 32'hFFFF80FF);
        step(1'b1, 1'b0, 9'h030, 32'h0, 3'b101, 1'b0);
        chk("lhu_030", rd_data, 32'h00007F01);
        step(1'b1, 1'b0, 9'h030, 32'h0, 3'b000, 1'b0);
        chk("lb_030", rd_data, 32'h00000001);

        step(1'b1, 1'b0, 9'h032, 32'h0, 3'b010, 1'b0);
        chk("lw_mis_err", 32'(err), 32'h1);
        chk("lw_mis_data", rd_data, 32'h0);
        step(1'b0, 1'b1, 9'h040, 32'hCAFEF00D, 3'b010, 1'b0);
        step(1'b0, 1'b1, 9'h041, 32'h00001234, 3'b001, 1'b0);
        chk("sh_mis_err", 32'(err), 32'h1);
        step(1'b1, 1'b0, 9'h040, 32'h0, 3'b010, 1'b0);
        chk("sh_mis_keep", rd_data, 32'hCAFEF00D);
        step(1'b1, 1'b0, 9'h040, 32'h0, 3'b011, 1'b0);
        chk("f3_011_err", 32'(err), 32'h1);

        step(1'b1, 1'b0, 9'h010, 32'h0, 3'b010, 1'b0);
        chk("b2b_0", rd_data, 32'hDEADBEEF);
        step(1'b1, 1'b0, 9'h030, 32'h0, 3'b010, 1'b0);
        chk("b2b_1", rd_data, 32'h80FF7F01);
        step(1'b1, 1'b0, 9'h010, 32'h0, 3'b010, 1'b0);
        chk("b2b_2", rd_data, 32'hDEADBEEF);

        step(1'b1, 1'b1, 9'h060, 32'h01020304, 3'b010, 1'b0);
        chk("both_no_vld", 32'(rd_valid), 32'h0);

        step(1'b0, 1'b1, 9'h050, 32'h11223344, 3'b010, 1'b0);
        step(1'b0, 1'b1, 9'h050, 32'h000000FF, 3'b000, 1'b0);
        step(1'b0, 1'b0, 9'h000, 32'h0, 3'b000, 1'b1);
        chk("rmw_rst_busy", 32'(busy), 32'h0);
        idle();
        step(1'b1, 1'b0, 9'h050, 32'h0, 3'b010, 1'b0);
        chk("rmw_rst_keep", rd_data, 32'h11223344);

        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            rd  = 1'($urandom_range(0, 1));
            wr  = ($urandom_range(0, 2) == 0);
            f3  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7))
                                              : 3'($urandom_range(0, 2));
            if ($urandom_range(0, 3) == 0 && !wr) f3 = 3'b100 | 3'($urandom_range(0, 1));
            step(rd, wr, 9'($urandom_range(0, 511)), $urandom, f3, rst);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
